float_sub_seq: RTL and testbench

Sequential IEEE-754 single-precision subtractor computing `result = a - b`. It is the inverse-operation companion to the team's combinational float adder. Unlike the adder, which only ever renormalizes by one right shift, this block must renormalize by up to 24 left shifts after cancellation, so it runs as a multi-cycle FSM. It sits between an operand source and a result sink, with valid/ready handshakes on both sides.

---
 rtl/float_sub_seq_pkg.sv | 22 ++
 rtl/float_sub_seq_align_shift.sv | 14 +
 rtl/float_sub_seq.sv | 158 +++++++++++++++
 tb/tb_float_sub_seq.sv | 139 +++++++++++++
 4 files changed

// File: rtl/float_sub_seq_pkg.sv
// Shared single-precision constants, FSM state type and field helpers for
// the float subtract datapath.
package float_pkg;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int WORD_W  = 1 + EXP_W + FRAC_W;
    // {carry, hidden, frac, guard}
    localparam int MANT_W  = FRAC_W + 3;

    typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, DONE} state_t;

    function automatic logic [EXP_W-1:0] exp_of(input logic [WORD_W-1:0] x);
        return x[WORD_W-2:FRAC_W];
    endfunction

    // Exponent-0 operands flush to zero: no hidden bit, fraction ignored.
    function automatic logic [MANT_W-1:0] mant_of(input logic [WORD_W-1:0] x);
        return (exp_of(x) == '0) ? '0 : {2'b01, x[FRAC_W-1:0], 1'b0};
    endfunction
endpackage

// File: rtl/float_sub_seq_align_shift.sv
// Combinational mantissa right shifter; shifts past the datapath width give 0.
module float_align_shift #(
    parameter int MANT_W = 26,
    parameter int SH_W   = 8
) (
    input  logic [MANT_W-1:0] mant,
    input  logic [SH_W-1:0]   shamt,
    output logic [MANT_W-1:0] mant_out
);
    always_comb begin
        if (shamt >= SH_W'(MANT_W)) mant_out = '0;
        else                         mant_out = mant >> shamt;
    end
endmodule

// File: rtl/float_sub_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (a - b), truncating,
// with one left-normalize step per cycle after cancellation.
module float_sub_seq #(
    parameter int EXP_W  = float_pkg::EXP_W,
    parameter int FRAC_W = float_pkg::FRAC_W,
    parameter int BIAS   = float_pkg::BIAS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   a,
    input  logic [EXP_W+FRAC_W:0]   b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    ovf,
    output logic                    zero
);
    import float_pkg::*;

    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int MW = FRAC_W + 3;
    localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(2 * BIAS + 1);
    localparam logic [EXP_W-1:0] EXP_TOP  = EXP_W'(2 * BIAS);

    state_t            state;
    logic [W-1:0]      a_r, b_r;
    logic              sign_r, sub_r;
    logic [EXP_W-1:0]  exp_r;
    logic [MW-1:0]     ml_r, ms_r, m_r;

    // Operand ordering and alignment, evaluated from the captured operands
    logic              sb, a_inf, b_inf, a_big;
    logic [EXP_W-1:0]  ea, eb, el, es;
    logic [MW-1:0]     ma, mb, ml_c, ms_c, ms_al, sum_c;

    assign sb    = ~b_r[W-1];
    assign ea    = exp_of(a_r);
    assign eb    = exp_of(b_r);
    assign ma    = mant_of(a_r);
    assign mb    = mant_of(b_r);
    assign a_inf = (ea == EXP_ONES);
    assign b_inf = (eb == EXP_ONES);
    assign a_big = (a_r[W-2:0] >= b_r[W-2:0]);
    assign el    = a_big ? ea : eb;
    assign es    = a_big ? eb : ea;
    assign ml_c  = a_big ? ma : mb;
    assign ms_c  = a_big ? mb : ma;

    float_align_shift #(.MANT_W(MW), .SH_W(EXP_W)) u_align (
        .mant     (ms_c),
        .shamt    (el - es),
        .mant_out (ms_al)
    );

    // L >= S by construction, so the subtract never wraps
    assign sum_c = sub_r ? (ml_r - ms_r) : (ml_r + ms_r);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            sign_r    <= 1'b0;
            sub_r     <= 1'b0;
            exp_r     <= '0;
            ml_r      <= '0;
            ms_r      <= '0;
            m_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= b;
                        in_ready <= 1'b0;
                        state    <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (a_inf || b_inf) begin
                        result    <= {(a_inf ? a_r[W-1] : sb), EXP_ONES, {FRAC_W{1'b0}}};
                        ovf       <= 1'b1;
                        zero      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        sign_r <= a_big ? a_r[W-1] : sb;
                        sub_r  <= (a_r[W-1] != sb);
                        exp_r  <= el;
                        ml_r   <= ml_c;
                        ms_r   <= ms_al;
                        state  <= ADDSUB;
                    end
                end
                ADDSUB: begin
                    if (sum_c == '0) begin
                        result    <= '0;
                        ovf       <= 1'b0;
                        zero      <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (sum_c[MW-1]) begin
                        if (exp_r == EXP_TOP) begin
                            result    <= {sign_r, EXP_ONES, {FRAC_W{1'b0}}};
                            ovf       <= 1'b1;
                            zero      <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            m_r   <= sum_c >> 1;
                            exp_r <= exp_r + 1'b1;
                            state <= NORM;
                        end
                    end else begin
                        m_r   <= sum_c;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (m_r[MW-2]) begin
                        result    <= {sign_r, exp_r, m_r[MW-3:1]};
                        ovf       <= 1'b0;
                        zero      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (exp_r == EXP_W'(1)) begin
                        result    <= '0;
                        ovf       <= 1'b0;
                        zero      <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        m_r   <= m_r << 1;
                        exp_r <= exp_r - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_float_sub_seq.sv
// Scoreboard bench for float_sub_seq: hand-derived results, latency,
// back-pressure, busy-input rejection and mid-operation reset.
module tb_float_sub_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, ovf, zero;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        zero;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    float_sub_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .zero      (zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic [31:0] eres, input logic eovf, input logic ezero,
                          input int elat, input int hold, input bit junk);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_; in_valid = 1'b1;
        e.res = eres; e.ovf = eovf; e.zero = ezero; e.lat = elat;
        sb_q.push_back(e);
        tick();
        if (junk) begin a = 32'h12345678; b = 32'h40490FDB; end
        else in_valid = 1'b0;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 60) begin tick(); n++; end
        in_valid = 1'b0;
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        e = sb_q.pop_front();
        check({tag, "_lat"}, 32'(n), 32'(e.lat));
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_res"}, result, e.res);
            check({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
            tick();
        end
        check({tag, "_res"}, result, e.res);
        check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
        check({tag, "_zero"}, 32'(zero), 32'(e.zero));
        check({tag, "_vld_held"}, 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vld_clr"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        repeat (2) tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        rst_n = 1'b1;
        tick();

        //      tag        a             b             result        ovf   zero  lat hold junk
        run_op("basic",   32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 3,  5,   1'b0);
        run_op("cancel",  32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b1, 2,  0,   1'b0);
        run_op("carry",   32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 1'b0, 3,  0,   1'b0);
        run_op("bsign",   32'h3F800000, 32'h40000000, 32'hBF800000, 1'b0, 1'b0, 4,  0,   1'b1);
        run_op("deep",    32'h3F800000, 32'h3F7FFFFF, 32'h33800000, 1'b0, 1'b0, 27, 0,   1'b0);
        run_op("ovf",     32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 1'b0, 2,  0,   1'b0);
        run_op("ainf",    32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1, 1'b0, 1,  0,   1'b0);
        run_op("binf",    32'h3F800000, 32'h7F800000, 32'hFF800000, 1'b1, 1'b0, 1,  0,   1'b0);
        run_op("denorm",  32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 2,  0,   1'b0);
        run_op("uflow",   32'h00800001, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 3,  0,   1'b0);
        run_op("sh24",    32'h4B800000, 32'h3F800000, 32'h4B7FFFFF, 1'b0, 1'b0, 4,  0,   1'b0);
        run_op("sh26",    32'h4C800000, 32'h3F800000, 32'h4C800000, 1'b0, 1'b0, 3,  0,   1'b0);

        // Abort a deep-cancellation operation while it is normalizing
        a = 32'h3F800000; b = 32'h3F7FFFFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        check("mid_norm_vld", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        tick();
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("no_stale_valid", 32'(seen), 32'd0);

        run_op("recover", 32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 3,  0,   1'b0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
